// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Elastic pipeline stage register placed between two pipeline stages
// (D->E, E->M, M->W). It carries one packed payload word with a valid/ready
// handshake. Flush inserts a bubble whose payload is RST_VAL. When the
// downstream stage stalls, the held entry is kept rather than dropped.
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   Defined   : adds a one-entry skid slot, and in_ready comes straight from a flop.
//   Undefined : single slot, and in_ready is combinational.
//
// Parameters
//   DATA_W  payload width (default: instr, pc, rfwa, rd1, rd2, imm; MSB first)
//   RST_VAL payload of a bubble (NOP instr, PC 0x3000, all else zero)
//   CNT_W   bubble counter width
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   flush      in   drops all held entries and this cycle's input
//   in_valid   in   upstream has a payload
//   in_ready   out  stage can accept this cycle
//   in_data    in   upstream payload
//   out_valid  out  out_data is a real instruction
//   out_ready  in   downstream consumes this cycle (low = stall)
//   out_data   out  registered payload
//   occupancy  out  number of entries held
//   bubble_cnt out  saturating count of cycles with out_valid low

module pipe_stage_reg #(
  parameter int                DATA_W  = 165,
  parameter logic [DATA_W-1:0] RST_VAL = {32'h0, 32'h0000_3000, 101'h0},
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              main_v;
  logic [DATA_W-1:0] main_d;
  logic              accept;
  logic              consume;

  assign out_valid = main_v;
  assign out_data  = main_d;

  // A flush also kills the input offered in the same cycle.
  assign accept  = in_valid && in_ready && !flush;
  assign consume = main_v && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_v;
  logic [DATA_W-1:0] skid_d;

  // Ready depends only on the skid flop, so it does not form a combinational
  // path from out_ready back to the upstream stage.
  assign in_ready  = !skid_v;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  // Two-entry FIFO. Skid holds the younger entry and only fills while main
  // is full and stalled. On a consume, skid moves forward into main.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_v <= 1'b0;
      main_d <= RST_VAL;
      skid_v <= 1'b0;
      skid_d <= RST_VAL;
    end else if (consume) begin
      if (skid_v) begin
        main_v <= 1'b1;
        main_d <= skid_d;
        if (accept) begin
          skid_v <= 1'b1;
          skid_d <= in_data;
        end else begin
          skid_v <= 1'b0;
          skid_d <= RST_VAL;
        end
      end else if (accept) begin
        main_v <= 1'b1;
        main_d <= in_data;
      end else begin
        main_v <= 1'b0;
        main_d <= RST_VAL;
      end
    end else if (accept) begin
      if (main_v) begin
        skid_v <= 1'b1;
        skid_d <= in_data;
      end else begin
        main_v <= 1'b1;
        main_d <= in_data;
      end
    end
  end
`else
  assign in_ready  = !main_v || out_ready;
  assign occupancy = {1'b0, main_v};

  // Single slot. When the entry leaves with nothing behind it, the payload
  // returns to RST_VAL, so an invalid slot always reads as a NOP bubble.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_v <= 1'b0;
      main_d <= RST_VAL;
    end else if (accept) begin
      main_v <= 1'b1;
      main_d <= in_data;
    end else if (consume) begin
      main_v <= 1'b0;
      main_d <= RST_VAL;
    end
  end
`endif

  // Performance-debug counter. It saturates instead of wrapping and is
  // deliberately untouched by flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (!main_v && bubble_cnt != CNT_MAX) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. A queue-based reference model
// predicts every output. The same file covers both builds
// (PIPE_STAGE_SKID_EN defined or undefined).

module tb_pipe_stage_reg;

  localparam int                DATA_W    = 165;
  localparam int                CNT_W     = 4;
  localparam int                CNT_MAX   = (1 << CNT_W) - 1;
  localparam int                INSTR_LSB = DATA_W - 32;
  localparam logic [DATA_W-1:0] RST_VAL   = {32'h0, 32'h0000_3000, 101'h0};
`ifdef PIPE_STAGE_SKID_EN
  localparam int                CAP       = 2;
`else
  localparam int                CAP       = 1;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: a FIFO of held payloads and an integer bubble count.
  logic [DATA_W-1:0] mq[$];
  int                m_cnt = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .RST_VAL(RST_VAL), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_in_ready();
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  function automatic logic [DATA_W-1:0] m_out_data();
    if (mq.size() > 0) return mq[0];
    return RST_VAL;
  endfunction

  function automatic logic [DATA_W-1:0] rand_payload();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom();
    return r[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] make_instr(input logic [31:0] instr);
    logic [DATA_W-1:0] p;
    p = rand_payload();
    p[DATA_W-1:INSTR_LSB] = instr;
    return p;
  endfunction

  // One clock edge. Decisions come from the pre-edge model state and the
  // current inputs. The model is updated and the DUT sampled 1 ns after the edge.
  task automatic tick();
    bit                acc;
    bit                con;
    bit                was_empty;
    logic [DATA_W-1:0] d;
    acc       = in_valid && m_in_ready() && !flush;
    con       = (mq.size() > 0) && out_ready;
    was_empty = (mq.size() == 0);
    d         = in_data;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (was_empty && m_cnt < CNT_MAX) m_cnt++;
      if (flush) mq.delete();
      else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(d);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = make_instr(32'h1234_5678); out_ready = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== RST_VAL) begin errors++; $display("[TB] FAIL reset_out_data got %h want %h", out_data, RST_VAL); end
    checks++; if (out_data[132:101] !== 32'h0000_3000) begin errors++; $display("[TB] FAIL reset_pc got %h want 00003000", out_data[132:101]); end
    checks++; if (bubble_cnt !== '0) begin errors++; $display("[TB] FAIL reset_bubble_cnt got %0d want 0", bubble_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL reset_occupancy got %0d want 0", occupancy); end
    reset = 1'b0;
  endtask

  task automatic test_streaming();
    int start_cnt;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_data = make_instr(k);
      tick();
      if (k == 1) start_cnt = m_cnt;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid[%0d] got %0b want 1", k, out_valid); end
      checks++; if (out_data[DATA_W-1:INSTR_LSB] !== k) begin errors++; $display("[TB] FAIL stream_instr[%0d] got %h want %h", k, out_data[DATA_W-1:INSTR_LSB], k); end
      checks++; if (out_data !== m_out_data()) begin errors++; $display("[TB] FAIL stream_data[%0d] got %h want %h", k, out_data, m_out_data()); end
      checks++; if (bubble_cnt !== start_cnt) begin errors++; $display("[TB] FAIL stream_bubble[%0d] got %0d want %0d", k, bubble_cnt, start_cnt); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_data = make_instr(32'hAAAA_0000);
    tick();
    in_data = make_instr(32'hBBBB_0000); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_data[DATA_W-1:INSTR_LSB] !== 32'hAAAA_0000 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold[%0d] got v=%0b %h want v=1 aaaa0000", c, out_valid, out_data[DATA_W-1:INSTR_LSB]); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready[%0d] got %0b want 0", c, in_ready); end
      checks++; if (occupancy !== CAP) begin errors++; $display("[TB] FAIL stall_occupancy[%0d] got %0d want %0d", c, occupancy, CAP); end
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_data[DATA_W-1:INSTR_LSB] !== 32'hBBBB_0000 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_release got v=%0b %h want v=1 bbbb0000", out_valid, out_data[DATA_W-1:INSTR_LSB]); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== RST_VAL) begin errors++; $display("[TB] FAIL stall_drain got v=%0b %h want v=0 bubble", out_valid, out_data); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < CAP; c++) begin
      in_data = rand_payload();
      tick();
    end
    in_data = make_instr(32'hCCCC_0000); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== RST_VAL) begin errors++; $display("[TB] FAIL flush_data got %h want %h", out_data, RST_VAL); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL flush_occupancy got %0d want 0", occupancy); end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || out_data[DATA_W-1:INSTR_LSB] === 32'hCCCC_0000) begin errors++; $display("[TB] FAIL flush_leak[%0d] got v=%0b %h want v=0 no cccc0000", c, out_valid, out_data[DATA_W-1:INSTR_LSB]); end
    end
  endtask

  task automatic test_saturation();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    checks++; if (bubble_cnt !== CNT_MAX) begin errors++; $display("[TB] FAIL sat_reach got %0d want %0d", bubble_cnt, CNT_MAX); end
    tick();
    checks++; if (bubble_cnt !== CNT_MAX) begin errors++; $display("[TB] FAIL sat_hold got %0d want %0d", bubble_cnt, CNT_MAX); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (bubble_cnt !== CNT_MAX) begin errors++; $display("[TB] FAIL sat_flush got %0d want %0d", bubble_cnt, CNT_MAX); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bubble_cnt !== '0) begin errors++; $display("[TB] FAIL sat_reset got %0d want 0", bubble_cnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      in_data   = rand_payload();
      #1;
      checks++; if (in_ready !== m_in_ready()) begin errors++; $display("[TB] FAIL rand_in_ready[%0d] got %0b want %0b", c, in_ready, m_in_ready()); end
      tick();
      checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("[TB] FAIL rand_valid[%0d] got %0b want %0b", c, out_valid, mq.size() > 0); end
      checks++; if (out_data !== m_out_data()) begin errors++; $display("[TB] FAIL rand_data[%0d] got %h want %h", c, out_data, m_out_data()); end
      checks++; if (occupancy !== mq.size()) begin errors++; $display("[TB] FAIL rand_occupancy[%0d] got %0d want %0d", c, occupancy, mq.size()); end
      checks++; if (bubble_cnt !== m_cnt) begin errors++; $display("[TB] FAIL rand_bubble[%0d] got %0d want %0d", c, bubble_cnt, m_cnt); end
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    $display("[TB] pipe_stage_reg bench, capacity %0d", CAP);
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
